// File: rtl/hazard_stall.sv
// hazard_stall: pipeline hazard and stall controller for the 5-stage RV32I core.
// Decides per-stage register enables, NOP bubbles and flushes from load-use
// dependencies, multi-cycle imem/dmem responses and EX-stage redirects.
// It also keeps saturating stall, load-use and flush event counters.
module hazard_stall #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,           // asynchronous, active-low
    input  logic [4:0]       id_rs1_s,
    input  logic [4:0]       id_rs2_s,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd_s,
    input  logic             ex_regf_we,
    input  logic             ex_is_load,
    input  logic             br_taken,
    input  logic             imem_resp,
    input  logic             mem_access,
    input  logic             dmem_resp,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_bubble,
    output logic             id_ex_we,
    output logic             id_ex_bubble,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN       = 1'b0,
        DMEM_WAIT = 1'b1
    } state_t;

    // Counter slots in the generated counter bank.
    localparam int CNT_STALL    = 0;
    localparam int CNT_LOAD_USE = 1;
    localparam int CNT_FLUSH    = 2;
    localparam int NUM_CNT      = 3;

    state_t           state_q, state_d;
    logic             discard_imem_q, discard_imem_d;

    logic             freeze;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             load_use;

    // Decision flags for the current cycle, used both for outputs and counters.
    logic             apply_redirect;
    logic             apply_load_use;
    logic             apply_imem_wait;
    logic             apply_discard;

    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];

    // A memory access without a response this cycle holds the entire pipeline.
    // A same-cycle response lets the pipeline advance without a stall.
    assign freeze = mem_access & ~dmem_resp;

    // A load in EX cannot forward to ID in time; x0 never creates a hazard.
    assign rs1_hit  = id_uses_rs1 & (id_rs1_s == ex_rd_s);
    assign rs2_hit  = id_uses_rs2 & (id_rs2_s == ex_rd_s);
    assign load_use = ex_is_load & ex_regf_we & (ex_rd_s != 5'd0) & (rs1_hit | rs2_hit);

    // Hazard priority when not frozen: redirect > load-use > imem wait > stale fetch drop.
    always_comb begin
        apply_redirect  = 1'b0;
        apply_load_use  = 1'b0;
        apply_imem_wait = 1'b0;
        apply_discard   = 1'b0;
        if (!freeze) begin
            if (br_taken) begin
                apply_redirect = 1'b1;
            end else if (load_use) begin
                apply_load_use = 1'b1;
            end else if (!imem_resp) begin
                apply_imem_wait = 1'b1;
            end else if (discard_imem_q) begin
                apply_discard = 1'b1;
            end
        end
    end

    // Stage enables and bubbles; reset forces a quiescent pipeline with NOPs loaded.
    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_bubble = 1'b0;
        id_ex_we     = 1'b1;
        id_ex_bubble = 1'b0;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
        if (!rst) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_bubble = 1'b1;
            id_ex_we     = 1'b0;
            id_ex_bubble = 1'b1;
            ex_mem_we    = 1'b0;
            mem_wb_we    = 1'b0;
        end else if (freeze) begin
            // Everything holds; a pending redirect or load-use stays in EX/ID
            // and is acted on once the memory response arrives.
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
        end else if (apply_redirect) begin
            // Squash the two younger wrong-path instructions.
            if_id_bubble = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (apply_load_use) begin
            // Hold IF and ID one cycle, insert a NOP behind the load.
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (apply_imem_wait || apply_discard) begin
            // No usable instruction: feed a NOP to ID and keep the PC.
            // For a discarded stale fetch the PC already holds the redirect target.
            pc_we        = 1'b0;
            if_id_bubble = 1'b1;
        end
    end

    // Next-state and wrong-path fetch tracking.
    always_comb begin
        state_d        = state_q;
        discard_imem_d = discard_imem_q;
        case (state_q)
            RUN:       if (freeze)  state_d = DMEM_WAIT;
            DMEM_WAIT: if (!freeze) state_d = RUN;
            default:   state_d = RUN;
        endcase
        if (apply_redirect) begin
            // An outstanding fetch at redirect time belongs to the wrong path.
            discard_imem_d = ~imem_resp;
        end else if (apply_discard) begin
            discard_imem_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RUN;
            discard_imem_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            discard_imem_q <= discard_imem_d;
        end
    end

    // Event strobes for the counter bank.
    assign cnt_inc[CNT_STALL]    = ~mem_wb_we;
    assign cnt_inc[CNT_LOAD_USE] = apply_load_use;
    assign cnt_inc[CNT_FLUSH]    = apply_redirect;

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : gen_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Saturating increment: the counter sticks at all-ones.
            always_comb begin
                cnt_d = cnt_q;
                if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            // Counter register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_val[gi] = cnt_q;
        end
    endgenerate

    assign stall_cnt    = cnt_val[CNT_STALL];
    assign load_use_cnt = cnt_val[CNT_LOAD_USE];
    assign flush_cnt    = cnt_val[CNT_FLUSH];

endmodule

// File: tb/tb_hazard_stall.sv
// Directed testbench for hazard_stall with 4-bit counters.
// Control outputs are packed as {pc_we, if_id_we, if_id_bubble, id_ex_we,
// id_ex_bubble, ex_mem_we, mem_wb_we} and compared against hand-derived codes.
module tb_hazard_stall;

    localparam int CNT_W = 4;

    localparam logic [6:0] C_RST   = 7'b0010100;
    localparam logic [6:0] C_NORM  = 7'b1101011;
    localparam logic [6:0] C_FRZ   = 7'b0000000;
    localparam logic [6:0] C_REDIR = 7'b1111111;
    localparam logic [6:0] C_LU    = 7'b0001111;
    localparam logic [6:0] C_IWAIT = 7'b0111011;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1_s, id_rs2_s, ex_rd_s;
    logic             id_uses_rs1, id_uses_rs2, ex_regf_we, ex_is_load;
    logic             br_taken, imem_resp, mem_access, dmem_resp;
    logic             pc_we, if_id_we, if_id_bubble, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we;
    logic [CNT_W-1:0] stall_cnt, load_use_cnt, flush_cnt;
    logic [6:0]       ctl;

    int checks = 0;
    int errors = 0;

    hazard_stall #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1_s     (id_rs1_s),
        .id_rs2_s     (id_rs2_s),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd_s      (ex_rd_s),
        .ex_regf_we   (ex_regf_we),
        .ex_is_load   (ex_is_load),
        .br_taken     (br_taken),
        .imem_resp    (imem_resp),
        .mem_access   (mem_access),
        .dmem_resp    (dmem_resp),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .if_id_bubble (if_id_bubble),
        .id_ex_we     (id_ex_we),
        .id_ex_bubble (id_ex_bubble),
        .ex_mem_we    (ex_mem_we),
        .mem_wb_we    (mem_wb_we),
        .stall_cnt    (stall_cnt),
        .load_use_cnt (load_use_cnt),
        .flush_cnt    (flush_cnt)
    );

    assign ctl = {pc_we, if_id_we, if_id_bubble, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs are applied 1 ns after a rising edge; this samples mid-cycle.
    task automatic mid_chk_ctl(input string tag, input logic [6:0] exp);
        #4;
        chk(tag, {25'd0, ctl}, {25'd0, exp});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1_s    = 5'd0;
        id_rs2_s    = 5'd0;
        id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0;
        ex_rd_s     = 5'd0;
        ex_regf_we  = 1'b0;
        ex_is_load  = 1'b0;
        br_taken    = 1'b0;
        imem_resp   = 1'b1;
        mem_access  = 1'b0;
        dmem_resp   = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("reset_ctl", {25'd0, ctl}, {25'd0, C_RST});
        chk("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("reset_flush_cnt", {28'd0, flush_cnt}, 32'd0);
        // Reset overrides even an active redirect.
        br_taken = 1'b1;
        #1;
        chk("reset_override_ctl", {25'd0, ctl}, {25'd0, C_RST});
        br_taken = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_held_lu_cnt", {28'd0, load_use_cnt}, 32'd0);
        rst = 1'b1;

        // Idle pipeline advances freely.
        mid_chk_ctl("idle", C_NORM);
        next_cycle();

        // Load-use through rs2: one bubble.
        ex_is_load = 1'b1; ex_regf_we = 1'b1; ex_rd_s = 5'd5;
        id_rs2_s = 5'd5; id_uses_rs2 = 1'b1;
        mid_chk_ctl("load_use_rs2", C_LU);
        next_cycle();
        chk("load_use_cnt_1", {28'd0, load_use_cnt}, 32'd1);
        // Load has moved to MEM; EX now holds the bubble.
        ex_is_load = 1'b0; ex_regf_we = 1'b0; ex_rd_s = 5'd0;
        mid_chk_ctl("after_load_use", C_NORM);
        next_cycle();

        // Load to x0 never stalls.
        ex_is_load = 1'b1; ex_regf_we = 1'b1; ex_rd_s = 5'd0; id_rs2_s = 5'd0;
        mid_chk_ctl("load_x0_no_stall", C_NORM);
        next_cycle();
        chk("load_use_cnt_x0", {28'd0, load_use_cnt}, 32'd1);

        // Load-use through rs1, then same index but rs1 not used.
        ex_rd_s = 5'd7; id_rs1_s = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0;
        mid_chk_ctl("load_use_rs1", C_LU);
        next_cycle();
        chk("load_use_cnt_2", {28'd0, load_use_cnt}, 32'd2);
        id_uses_rs1 = 1'b0;
        mid_chk_ctl("rs1_unused", C_NORM);
        next_cycle();
        idle_inputs();

        // dmem latency 3: two frozen cycles, advance on the response.
        mem_access = 1'b1; dmem_resp = 1'b0;
        mid_chk_ctl("dmem_wait_1", C_FRZ);
        next_cycle();
        mid_chk_ctl("dmem_wait_2", C_FRZ);
        next_cycle();
        dmem_resp = 1'b1;
        mid_chk_ctl("dmem_resp", C_NORM);
        next_cycle();
        chk("stall_cnt_2", {28'd0, stall_cnt}, 32'd2);
        idle_inputs();
        mid_chk_ctl("after_dmem", C_NORM);
        next_cycle();

        // Redirect during freeze is deferred to the response cycle.
        mem_access = 1'b1; dmem_resp = 1'b0; br_taken = 1'b1;
        mid_chk_ctl("redirect_frozen", C_FRZ);
        next_cycle();
        chk("flush_cnt_frozen", {28'd0, flush_cnt}, 32'd0);
        dmem_resp = 1'b1;
        mid_chk_ctl("redirect_thaw", C_REDIR);
        next_cycle();
        chk("flush_cnt_1", {28'd0, flush_cnt}, 32'd1);
        chk("stall_cnt_3", {28'd0, stall_cnt}, 32'd3);
        idle_inputs();

        // Redirect with imem outstanding: stale response must be dropped.
        br_taken = 1'b1; imem_resp = 1'b0;
        mid_chk_ctl("redirect_imem_out", C_REDIR);
        next_cycle();
        chk("flush_cnt_2", {28'd0, flush_cnt}, 32'd2);
        br_taken = 1'b0;
        mid_chk_ctl("imem_wait", C_IWAIT);
        next_cycle();
        imem_resp = 1'b1;
        mid_chk_ctl("stale_dropped", C_IWAIT);
        next_cycle();
        mid_chk_ctl("fetch_after_drop", C_NORM);
        next_cycle();

        // Redirect beats a simultaneous load-use.
        br_taken = 1'b1; ex_is_load = 1'b1; ex_regf_we = 1'b1; ex_rd_s = 5'd9;
        id_rs1_s = 5'd9; id_uses_rs1 = 1'b1;
        mid_chk_ctl("redirect_over_lu", C_REDIR);
        next_cycle();
        chk("flush_cnt_3", {28'd0, flush_cnt}, 32'd3);
        chk("lu_cnt_unchanged", {28'd0, load_use_cnt}, 32'd2);
        idle_inputs();

        // 20 stall cycles saturate the 4-bit stall counter.
        mem_access = 1'b1; dmem_resp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
        end
        chk("stall_cnt_sat", {28'd0, stall_cnt}, 32'd15);

        // Asynchronous reset mid-wait, no clock edge involved.
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_ctl", {25'd0, ctl}, {25'd0, C_RST});
        chk("async_rst_stall", {28'd0, stall_cnt}, 32'd0);
        chk("async_rst_flush", {28'd0, flush_cnt}, 32'd0);
        // Late response after reset without an access is ignored.
        mem_access = 1'b0; dmem_resp = 1'b1;
        next_cycle();
        rst = 1'b1;
        mid_chk_ctl("post_rst_late_resp", C_NORM);
        next_cycle();
        chk("post_rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall.md
Name: hazard_stall

Overview:
- Producer-side counterpart to the operand forwarding unit in the 5-stage RV32I pipeline.
- Forwarding consumes EX/MEM and MEM/WB results. This block decides when results cannot be forwarded in time, or when the pipeline must not advance.
- It generates per-stage write enables, bubbles and flushes for load-use hazards, multi-cycle imem/dmem responses and EX-stage branch redirects.
- It also keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous reset, active-low
- id_rs1_s  input  5  rs1 index of instruction in ID
- id_rs2_s  input  5  rs2 index of instruction in ID
- id_uses_rs1  input  1  ID instruction reads rs1
- id_uses_rs2  input  1  ID instruction reads rs2
- ex_rd_s  input  5  rd index of instruction in EX
- ex_regf_we  input  1  EX instruction writes regfile
- ex_is_load  input  1  EX instruction is a load
- br_taken  input  1  EX resolves a taken branch/jump (redirect)
- imem_resp  input  1  instruction fetch response valid this cycle
- mem_access  input  1  MEM-stage instruction has nonzero rmask/wmask
- dmem_resp  input  1  data memory response valid this cycle
- pc_we  output  1  PC register enable
- if_id_we  output  1  IF/ID register enable
- if_id_bubble  output  1  load NOP into IF/ID
- id_ex_we  output  1  ID/EX register enable
- id_ex_bubble  output  1  load NOP into ID/EX
- ex_mem_we  output  1  EX/MEM register enable
- mem_wb_we  output  1  MEM/WB register enable
- stall_cnt  output  CNT_W  cycles with mem_wb_we=0
- load_use_cnt  output  CNT_W  load-use bubbles inserted
- flush_cnt  output  CNT_W  redirects applied

Behaviour:
- States: RUN, DMEM_WAIT. One extra flop: discard_imem.
- rst low (async): state=RUN, discard_imem=0, counters=0. All *_we=0, both bubbles=1, regardless of inputs.
- freeze = mem_access & ~dmem_resp. Combinational, so a same-cycle response does not stall.
- RUN -> DMEM_WAIT when freeze. DMEM_WAIT -> RUN on the cycle dmem_resp=1; that cycle behaves as RUN (pipeline advances).
- While freeze (either state): all five *_we=0, bubbles=0. load_use and redirect are ignored; they remain visible after the thaw because EX/ID are held.
- load_use = ex_is_load & ex_regf_we & ex_rd_s!=0 & ((id_uses_rs1 & id_rs1_s==ex_rd_s) | (id_uses_rs2 & id_rs2_s==ex_rd_s)).
- Not frozen, priority redirect > load_use > imem wait:
  - br_taken: all we=1, if_id_bubble=1, id_ex_bubble=1. If imem_resp=0 this cycle, set discard_imem=1 (wrong-path fetch outstanding). flush_cnt++.
  - load_use: pc_we=0, if_id_we=0, id_ex_we=1 with id_ex_bubble=1, ex_mem_we=1, mem_wb_we=1. load_use_cnt++. Exactly one bubble per load: the next cycle the load is in MEM, so no match.
  - imem_resp=0: pc_we=0, if_id_we=1 with if_id_bubble=1; downstream we=1.
  - discard_imem=1 and imem_resp=1: clear discard_imem, pc_we=0, if_id_bubble=1 (stale instruction dropped; PC keeps redirected target).
  - else: all we=1, bubbles=0.
- stall_cnt increments on every non-reset cycle with mem_wb_we=0.
- All counters saturate at 2^CNT_W-1, no wrap.
- Counter and discard_imem updates are registered on the clk edge. All other outputs are combinational from state and inputs.
- Reset mid-DMEM_WAIT: returns to RUN immediately. A late dmem_resp after reset is ignored unless mem_access=1.

Test Plan:
- Load-use: ex_is_load=1, ex_regf_we=1, ex_rd_s=5, id_rs2_s=5, id_uses_rs2=1 -> one cycle pc_we=0, if_id_we=0, id_ex_bubble=1; next cycle all we=1; load_use_cnt=1. Repeat with ex_rd_s=0 -> no stall.
- dmem latency 3: mem_access=1, dmem_resp low 2 cycles then high -> all we=0 for 2 cycles, all we=1 on the response cycle; stall_cnt=2; state back to RUN.
- Redirect during freeze: br_taken=1 while DMEM_WAIT -> no bubbles while frozen. On the dmem_resp cycle: if_id_bubble=id_ex_bubble=1, flush_cnt=1.
- Redirect with imem outstanding: br_taken=1, imem_resp=0, then imem_resp=1 two cycles later -> discard_imem set, that response produces if_id_bubble=1 and pc_we=0, discard_imem clears, following fetch passes normally.
- Redirect and load-use same cycle -> redirect wins: load_use_cnt unchanged, flush_cnt+1.
- Counter saturation (CNT_W=4): 20 stall cycles -> stall_cnt=15. Async rst low mid-test -> counters 0 and we outputs 0 without a clock edge.
